// File: rtl/adder_packer.sv
// Upstream driver for the four-operand adder: gathers x, y, z, w and cin into the packed ins bus,
// waits out the adder register stage, returns sm_r/sm_zero_r and cross-checks them against a local sum.
module adder_packer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [W-1:0]   op_data,
  input  logic           op_cin,
  output logic [4*W:0]   ins,
  input  logic [W+1:0]   sm_r,
  input  logic           sm_zero_r,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W+1:0]   res_sum,
  output logic           res_zero,
  output logic           chk_err
);

  // Both streams use plain valid/ready: a beat or result transfers on a rising edge where
  // valid and ready are both high; the sender holds data stable while valid is high and ready low.

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  logic [1:0]   state;
  logic [1:0]   idx;
  logic [W+1:0] expected;
  logic [W+1:0] ins_sum;

  // Zero-extended to W+2 bits; 4*(2^W-1)+1 always fits.
  always_comb begin
    ins_sum = {2'b00, ins[W-1:0]}
            + {2'b00, ins[2*W-1:W]}
            + {2'b00, ins[3*W-1:2*W]}
            + {2'b00, ins[4*W-1:3*W]}
            + {{(W+1){1'b0}}, ins[4*W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= 2'd0;
      ins       <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_zero  <= 1'b0;
      chk_err   <= 1'b0;
      expected  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (!op_ready) begin
            // First cycle out of reset: open the operand stream.
            op_ready <= 1'b1;
          end else if (op_valid) begin
            ins[idx*W +: W] <= op_data;
            if (idx == 2'd0) ins[4*W] <= op_cin;
            if (idx == 2'd3) begin
              state    <= SETTLE;
              op_ready <= 1'b0;
              idx      <= 2'd0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        SETTLE: begin
          expected <= ins_sum;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          res_sum   <= sm_r;
          res_zero  <= sm_zero_r;
          res_valid <= 1'b1;
          if ((sm_r != expected) || (sm_zero_r != (sm_r == '0))) chk_err <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_packer.sv
// Bench for adder_packer: a behavioural registered adder closes the loop, a scoreboard queue
// holds {zero, sum} expected per transaction and is checked when a result appears.
module tb_adder_packer;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           op_valid;
  logic           op_ready;
  logic [W-1:0]   op_data;
  logic           op_cin;
  logic [4*W:0]   ins;
  logic [W+1:0]   sm_r;
  logic           sm_zero_r;
  logic           res_valid;
  logic           res_ready;
  logic [W+1:0]   res_sum;
  logic           res_zero;
  logic           chk_err;

  int checks;
  int errors;
  logic [W+2:0] exp_q[$];
  logic         exp_err;
  logic         inject;
  logic [W+1:0] model_val;

  adder_packer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_cin(op_cin),
    .ins(ins), .sm_r(sm_r), .sm_zero_r(sm_zero_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_zero(res_zero),
    .chk_err(chk_err)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  // behavioural adder with one register stage; inject corrupts the sum by +1
  always_comb begin
    model_val = {2'b00, ins[W-1:0]} + {2'b00, ins[2*W-1:W]} + {2'b00, ins[3*W-1:2*W]}
              + {2'b00, ins[4*W-1:3*W]} + {{(W+1){1'b0}}, ins[4*W]}
              + {{(W+1){1'b0}}, inject};
  end

  always @(posedge clk) begin
    sm_r      <= model_val;
    sm_zero_r <= (model_val == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: returns one cycle after the accepting edge
  task automatic drive_beat(input logic [W-1:0] d, input logic c);
    bit ok;
    ok = 1'b0;
    op_valid = 1'b1;
    op_data  = d;
    op_cin   = c;
    for (int n = 0; n < 40 && !ok; n++) begin
      ok = op_ready;
      tick();
    end
    op_valid = 1'b0;
    if (!ok) check("beat_timeout", 0, 1);
  endtask

  task automatic send_txn(input int x, input int y, input int z, input int w,
                          input int cin, input int max_gap);
    logic [W+1:0] s;
    s = W'(x) + W'(y);
    s = {2'b00, x[W-1:0]} + {2'b00, y[W-1:0]} + {2'b00, z[W-1:0]} + {2'b00, w[W-1:0]}
      + {{(W+1){1'b0}}, cin[0]} + {{(W+1){1'b0}}, inject};
    exp_q.push_back({(s == '0), s});
    repeat ($urandom_range(0, max_gap)) tick();
    drive_beat(x[W-1:0], cin[0]);
    repeat ($urandom_range(0, max_gap)) tick();
    drive_beat(y[W-1:0], 1'b0);
    repeat ($urandom_range(0, max_gap)) tick();
    drive_beat(z[W-1:0], 1'b1);
    repeat ($urandom_range(0, max_gap)) tick();
    drive_beat(w[W-1:0], 1'b1);
  endtask

  // scoreboard side: wait for a result, compare, optionally backpressure, then handshake
  task automatic recv(input int hold, input bit pulse);
    bit got;
    logic [W+2:0] e;
    logic [W+1:0] held_sum;
    logic [4*W:0] held_ins;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      if (res_valid) got = 1'b1;
      else tick();
    end
    check("res_timeout", got, 1);
    if (!got) return;
    if (exp_q.size() == 0) begin
      check("queue_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("res_sum", res_sum, e[W+1:0]);
    check("res_zero", res_zero, e[W+2]);
    check("chk_err", chk_err, exp_err);
    held_sum = res_sum;
    held_ins = ins;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        op_valid = (i % 2 == 0);
        op_data  = W'($urandom);
      end
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_sum", res_sum, held_sum);
      check("hold_op_ready", op_ready, 0);
      check("hold_ins", ins, held_ins);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_op_ready", op_ready, 1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_err   = 1'b0;
    inject    = 1'b0;
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_data   = '0;
    op_cin    = 1'b0;
    res_ready = 1'b0;
    repeat (3) tick();
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_zero", res_zero, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_ins", ins, 0);
    rst = 1'b0;
    check("rel_op_ready0", op_ready, 0);
    tick();
    check("rel_op_ready1", op_ready, 1);

    // basic sum with latency
    send_txn(1, 2, 3, 4, 1, 0);
    check("settle_ins", ins, 33'h1_04030201);
    check("lat_e0", res_valid, 0);
    tick();
    check("lat_e1", res_valid, 0);
    tick();
    check("lat_e2", res_valid, 1);
    recv(0, 0);

    send_txn(255, 255, 255, 255, 1, 0);
    recv(0, 0);
    send_txn(0, 0, 0, 0, 0, 0);
    recv(0, 0);

    // bubbles and backpressure with ignored op_valid pulses
    send_txn(9, 17, 33, 65, 0, 3);
    recv(5, 1);
    send_txn(10, 20, 30, 40, 1, 1);
    recv(0, 0);

    // error injection: sticky through two good transactions
    inject = 1'b1;
    send_txn(1, 2, 3, 4, 0, 0);
    exp_err = 1'b1;
    recv(0, 0);
    inject = 1'b0;
    send_txn(7, 8, 9, 10, 1, 1);
    recv(1, 0);
    send_txn(100, 50, 25, 12, 0, 1);
    recv(0, 0);
    check("err_sticky", chk_err, 1);

    // reset mid-operation after x and y
    drive_beat(8'h11, 1'b1);
    drive_beat(8'h22, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_ins", ins, 0);
    check("mid_rst_op_ready", op_ready, 0);
    check("mid_rst_chk_err", chk_err, 0);
    exp_err = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rel_op_ready0", op_ready, 0);
    tick();
    check("mid_rel_op_ready1", op_ready, 1);
    send_txn(5, 6, 7, 8, 0, 0);
    recv(0, 0);

    // random traffic
    for (int t = 0; t < 8; t++) begin
      send_txn($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 1), 2);
      recv($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
